// File: rtl/key_reduction_iter.sv
// Iterative key reducer: folds a KEY_W-bit key in half once per clock until OUT_W bits remain.
// Optional build macro KEYRED_SALT_EN adds a salt port that is XORed into the reduced key.
module key_reduction_iter #(
  parameter int KEY_W = 512,
  parameter int OUT_W = 16,
  parameter int ROT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [KEY_W-1:0] key,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] red_key,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef KEYRED_SALT_EN
  input  logic [OUT_W-1:0] salt,
`endif
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a key, in_ready high
  // FOLD  | one fold round per clock, rcnt = round index
  // DONE  | red_key presented, waiting for out_ready
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FOLD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int ROUNDS = $clog2(KEY_W / OUT_W);
  localparam int RCNT_W = $clog2(ROUNDS + 1);
  localparam logic [RCNT_W-1:0] LAST = RCNT_W'(ROUNDS - 1);

  logic [1:0]        state;
  logic [RCNT_W-1:0] rcnt;
  logic [KEY_W-1:0]  work;
  logic [KEY_W-1:0]  fold [ROUNDS];
  logic [KEY_W-1:0]  fold_sel;
`ifdef KEYRED_SALT_EN
  logic [OUT_W-1:0]  salt_q;
`endif

  // Each round has a fixed half-width and rotation, so every round is static wiring.
  for (genvar r = 0; r < ROUNDS; r++) begin : g_round
    localparam int H = KEY_W >> (r + 1);
    localparam int S = (ROT * (r + 1)) % H;
    logic [H-1:0] hi_rot;
    if (S == 0) begin : g_norot
      assign hi_rot = work[2*H-1:H];
    end else begin : g_rot
      assign hi_rot = {work[2*H-1-S:H], work[2*H-1:2*H-S]};
    end
    assign fold[r] = {{(KEY_W-H){1'b0}}, work[H-1:0] ^ hi_rot};
  end

  always_comb begin
    fold_sel = '0;
    for (int i = 0; i < ROUNDS; i++) begin
      if (rcnt == RCNT_W'(i)) fold_sel = fold[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rcnt      <= '0;
      work      <= '0;
      red_key   <= '0;
      out_valid <= 1'b0;
`ifdef KEYRED_SALT_EN
      salt_q    <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            work  <= key;
            rcnt  <= '0;
`ifdef KEYRED_SALT_EN
            salt_q <= salt;
`endif
            state <= ST_FOLD;
          end
        end
        ST_FOLD: begin
          work <= fold_sel;
          rcnt <= rcnt + 1'b1;
          if (rcnt == LAST) begin
`ifdef KEYRED_SALT_EN
            red_key <= fold_sel[OUT_W-1:0] ^ salt_q;
`else
            red_key <= fold_sel[OUT_W-1:0];
`endif
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

endmodule
